// File: rtl/mux_scan_seq_if.sv
// Bundle of the word-in stream, the 16:1 mux drive/return pair and the serial bit-out stream.
// master = surrounding environment, slave = the scan sequencer.
interface mux_scan_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din;
  logic [4:0]  in_len;
  logic [15:0] a;
  logic [3:0]  sel;
  logic        y;
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic        out_last;
  logic        busy;

  modport master (
    output in_valid, din, in_len, y, out_ready,
    input  in_ready, a, sel, out_valid, out_bit, out_last, busy
  );

  modport slave (
    input  in_valid, din, in_len, y, out_ready,
    output in_ready, a, sel, out_valid, out_bit, out_last, busy
  );
endinterface

// File: rtl/mux_scan_seq.sv
// Latches a 16-bit word, walks the select of an external 16:1 mux across it and
// streams the returned bit out under valid/ready, one frame of 1..16 bits per word.
module mux_scan_seq #(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  mux_scan_seq_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [15:0] a_r;
  logic [3:0]  sel_r;
  logic [4:0]  cnt;
  logic [4:0]  len_r;
  logic [4:0]  len_norm;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        out_last_r;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    len_norm = bus.in_len;
    if (bus.in_len == 5'd0 || bus.in_len > 5'd16) len_norm = 5'd16;
  end

  // Handshake flags are registered alongside the state, so nothing in in_valid/out_ready
  // reaches them combinationally.
  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_r         <= 16'h0000;
      sel_r       <= 4'h0;
      cnt         <= 5'd0;
      len_r       <= 5'd16;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r         <= bus.din;
            len_r       <= len_norm;
            cnt         <= 5'd0;
            sel_r       <= MSB_FIRST ? 4'hF : 4'h0;
            out_last_r  <= (len_norm == 5'd1);
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (out_last_r) begin
              // a and sel deliberately hold so the mux keeps its last input stable.
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              state       <= IDLE;
            end else begin
              cnt        <= cnt + 5'd1;
              sel_r      <= MSB_FIRST ? sel_r - 4'd1 : sel_r + 4'd1;
              // Next beat is final when the advanced count reaches len_r-1.
              out_last_r <= (cnt + 5'd2 == len_r);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a         = a_r;
  assign bus.sel       = sel_r;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_bit   = bus.y;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench: drives an LSB-first and an MSB-first sequencer in lockstep, each
// closing the loop through a behavioural 16:1 mux, and checks every beat against a queue.
module tb_mux_scan_seq;

  typedef struct packed {
    logic        b;
    logic [3:0]  s;
    logic        l;
    logic [15:0] w;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] din;
  logic [4:0]  in_len;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit per_chk = 0;
  int prev_acc;
  int n_acc;

  beat_t       sb [2][$];
  logic [3:0]  last_sel [2];
  logic [15:0] last_a [2];

  mux_scan_seq_if if0 ();
  mux_scan_seq_if if1 ();

  mux_scan_seq #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(if0));
  mux_scan_seq #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.in_valid  = in_valid;
  assign if0.din       = din;
  assign if0.in_len    = in_len;
  assign if0.out_ready = out_ready;
  assign if0.y         = if0.a[if0.sel];
  assign if1.in_valid  = in_valid;
  assign if1.din       = din;
  assign if1.in_len    = in_len;
  assign if1.out_ready = out_ready;
  assign if1.y         = if1.a[if1.sel];

  logic        ov [2], rdy [2], bsy [2], ob [2], lst [2];
  logic [3:0]  sl [2];
  logic [15:0] aa [2];
  assign ov[0] = if0.out_valid; assign ov[1] = if1.out_valid;
  assign rdy[0] = if0.in_ready; assign rdy[1] = if1.in_ready;
  assign bsy[0] = if0.busy;     assign bsy[1] = if1.busy;
  assign ob[0] = if0.out_bit;   assign ob[1] = if1.out_bit;
  assign lst[0] = if0.out_last; assign lst[1] = if1.out_last;
  assign sl[0] = if0.sel;       assign sl[1] = if1.sel;
  assign aa[0] = if0.a;         assign aa[1] = if1.a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int norm_len(input logic [4:0] l);
    return (l == 5'd0 || l > 5'd16) ? 16 : int'(l);
  endfunction

  // Monitor: compare every valid cycle against the scoreboard head, pop on beats,
  // and push the expected frame when a word is accepted.
  always @(negedge clk) begin
    beat_t ent;
    int    len;
    int    idx;
    bit    exp_busy;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        sb[d].delete();
        last_sel[d] = 4'h0;
        last_a[d]   = 16'h0000;
      end else begin
        exp_busy = (sb[d].size() != 0);
        check($sformatf("out_valid%0d", d), ov[d], exp_busy);
        check($sformatf("in_ready%0d", d), rdy[d], !exp_busy);
        check($sformatf("busy%0d", d), bsy[d], exp_busy);
        if (ov[d] && exp_busy) begin
          ent = sb[d][0];
          check($sformatf("out_bit%0d", d), ob[d], ent.b);
          check($sformatf("sel%0d", d), sl[d], ent.s);
          check($sformatf("out_last%0d", d), lst[d], ent.l);
          check($sformatf("a%0d", d), aa[d], ent.w);
          if (out_ready) begin
            void'(sb[d].pop_front());
            last_sel[d] = ent.s;
            last_a[d]   = ent.w;
          end
        end else if (!exp_busy) begin
          check($sformatf("idle_sel%0d", d), sl[d], last_sel[d]);
          check($sformatf("idle_a%0d", d), aa[d], last_a[d]);
          check($sformatf("idle_last%0d", d), lst[d], 1'b0);
        end
        if (in_valid && !exp_busy) begin
          len = norm_len(in_len);
          for (int i = 0; i < len; i++) begin
            idx   = (d == 1) ? 15 - i : i;
            ent.b = din[idx];
            ent.s = 4'(idx);
            ent.l = (i == len - 1);
            ent.w = din;
            sb[d].push_back(ent);
          end
          if (d == 0 && per_chk) begin
            if (prev_acc >= 0) check("accept_period", cyc - prev_acc, 5);
            prev_acc = cyc;
            n_acc++;
          end
        end
      end
    end
  end

  // Out-ready pattern bit k applies to the k-th cycle after acceptance; 1 once exhausted.
  task automatic send(input logic [15:0] w, input logic [4:0] len,
                      input logic [7:0] rpat, input int rlen, input int exp_cyc);
    int n, k, t;
    @(posedge clk); #1;
    in_valid = 1'b1; din = w; in_len = len;
    t = 0;
    @(negedge clk);
    while (!if0.in_ready && t < 100) begin t++; @(negedge clk); end
    check("accept_timeout", t < 100, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; din = 16'($urandom);
    k = 0;
    out_ready = (k < rlen) ? rpat[k] : 1'b1;
    @(negedge clk);
    check("latency_lsb", if0.out_valid, 1'b1);
    check("latency_msb", if1.out_valid, 1'b1);
    n = 0;
    while (if0.out_valid && n < 200) begin
      n++;
      @(posedge clk); #1;
      k++;
      out_ready = (k < rlen) ? rpat[k] : 1'b1;
      @(negedge clk);
    end
    check("frame_timeout", n < 200, 1'b1);
    if (exp_cyc >= 0) check("frame_cycles", n, exp_cyc);
    check("sb_empty_lsb", sb[0].size(), 0);
    check("sb_empty_msb", sb[1].size(), 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!(if0.in_ready && if1.in_ready && sb[0].size() == 0 && sb[1].size() == 0) && t < 200) begin
      t++;
      @(negedge clk);
    end
    check("idle_timeout", t < 200, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din = 16'h0; in_len = 5'd0;
    #3;
    for (int d = 0; d < 2; d++) begin
      check("rst_out_valid", ov[d], 1'b0);
      check("rst_busy", bsy[d], 1'b0);
      check("rst_last", lst[d], 1'b0);
      check("rst_a", aa[d], 16'h0000);
      check("rst_sel", sl[d], 4'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", if0.in_ready & if1.in_ready, 1'b1);

    // Full word both directions, then short frame with stalls, then length normalisation.
    send(16'hA5C3, 5'd16, 8'hFF, 0, 16);
    send(16'h0005, 5'd3, 8'b0001_1001, 5, 5);
    send(16'h1234, 5'd0, 8'hFF, 0, 16);
    send(16'hBEEF, 5'd20, 8'hFF, 0, 16);
    send(16'h8001, 5'd1, 8'hFF, 0, 1);

    // Back-to-back offers: one accept every len+1 cycles, din churn during SEND ignored.
    prev_acc = -1; n_acc = 0; per_chk = 1'b1;
    @(posedge clk); #1;
    in_len = 5'd4; in_valid = 1'b1; out_ready = 1'b1;
    repeat (26) begin
      din = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    per_chk = 1'b0;
    check("accept_count", n_acc, 6);
    wait_idle();

    // Reset after the 5th beat of a 16-bit frame, then a clean frame.
    @(posedge clk); #1;
    in_valid = 1'b1; din = 16'hF0F0; in_len = 5'd16; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("abort_out_valid", ov[d], 1'b0);
      check("abort_busy", bsy[d], 1'b0);
      check("abort_a", aa[d], 16'h0000);
      check("abort_sel", sl[d], 4'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    send(16'h3C96, 5'd16, 8'hFF, 0, 16);

    // Random words, lengths and back-pressure.
    for (int i = 0; i < 6; i++)
      send(16'($urandom), 5'($urandom_range(0, 31)), 8'($urandom), 8, -1);

    wait_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
